// File: rtl/fx_scheduler.sv
// rtl/fx_scheduler.sv - per-frame L/R sequencer through a shared effect unit with debounced click-free effect switching
module fx_scheduler #(
    parameter int WIDTH     = 32,
    parameter int SEL_W     = 2,
    parameter int DEBOUNCE  = 50000,
    parameter int GAIN_BITS = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_strobe,
    input  logic [WIDTH-1:0] data_L_in,
    input  logic [WIDTH-1:0] data_R_in,
    input  logic [SEL_W-1:0] sel_raw,
    input  logic             fx_en,
    output logic             fx_req,
    output logic             fx_chan,
    output logic [WIDTH-1:0] fx_data,
    output logic [SEL_W-1:0] fx_sel,
    input  logic             fx_ack,
    input  logic [WIDTH-1:0] fx_result,
    output logic [WIDTH-1:0] data_L_out,
    output logic [WIDTH-1:0] data_R_out,
    output logic             out_valid,
    output logic             overrun,
    output logic             fx_timeout
);

    // Product width: sign-extended sample times a non-negative gain of GAIN_BITS+1 bits.
    localparam int PW   = WIDTH + GAIN_BITS + 2;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int DB_W = $clog2(DEBOUNCE + 1);

    localparam logic [GAIN_BITS:0] UNITY    = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [GAIN_BITS:0] GAIN_ONE = {{GAIN_BITS{1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {IDLE, REQ_L, REQ_R, APPLY} state_t;
    typedef enum logic [1:0] {RUN, DOWN, UP} ramp_t;

    state_t state, state_next;
    ramp_t  ramp, ramp_next;

    logic             fx_req_next;
    logic             fx_chan_next;
    logic [TO_W-1:0]  wait_cnt;
    logic             ack_ok;
    logic             to_hit;
    logic             chan_done;

    logic [WIDTH-1:0] sample_l;
    logic [WIDTH-1:0] sample_r;

    logic [GAIN_BITS:0] gain, gain_next;
    logic [SEL_W-1:0]   sel_next;

    logic [SEL_W-1:0] sync_a;
    logic [SEL_W-1:0] sync_b;
    logic [SEL_W-1:0] cand;
    logic [DB_W-1:0]  db_cnt;
    logic [SEL_W-1:0] sel_pending;

    logic signed [PW-1:0] samp_ext_l;
    logic signed [PW-1:0] samp_ext_r;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod_l;
    logic signed [PW-1:0] prod_r;
    logic [WIDTH-1:0]     scaled_l;
    logic [WIDTH-1:0]     scaled_r;

    // An ack only counts while a request is actually outstanding, so late or stray acks are ignored.
    assign ack_ok    = fx_ack & fx_req;
    assign to_hit    = fx_req & ~fx_ack & (wait_cnt == TO_LAST);
    assign chan_done = ack_ok | to_hit;

    // The sample being offered is the still-dry latched value of the active channel.
    assign fx_data = fx_req ? (fx_chan ? sample_r : sample_l) : '0;

    assign samp_ext_l = {{(PW-WIDTH){sample_l[WIDTH-1]}}, sample_l};
    assign samp_ext_r = {{(PW-WIDTH){sample_r[WIDTH-1]}}, sample_r};
    assign gain_ext   = {{(PW-GAIN_BITS-1){1'b0}}, gain};
    assign prod_l     = samp_ext_l * gain_ext;
    assign prod_r     = samp_ext_r * gain_ext;
    assign scaled_l   = WIDTH'(prod_l >>> GAIN_BITS);
    assign scaled_r   = WIDTH'(prod_r >>> GAIN_BITS);

    // Main sequencer next state; request is held off for one cycle between the L and R windows.
    always_comb begin
        state_next   = state;
        fx_req_next  = 1'b0;
        fx_chan_next = 1'b0;
        case (state)
            IDLE: begin
                if (frame_strobe) begin
                    state_next = fx_en ? REQ_L : APPLY;
                end
            end
            REQ_L: begin
                if (chan_done) begin
                    state_next = REQ_R;
                end
            end
            REQ_R: begin
                if (chan_done) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        fx_req_next  = (state_next == REQ_L) || ((state_next == REQ_R) && (state == REQ_R));
        fx_chan_next = (state_next == REQ_R);
    end

    // Sequencer state and handshake outputs; async reset abandons any pending request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            fx_req  <= 1'b0;
            fx_chan <= 1'b0;
        end else begin
            state   <= state_next;
            fx_req  <= fx_req_next;
            fx_chan <= fx_chan_next;
        end
    end

    // Ack watchdog: counts the cycles the current request has been outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!fx_req) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    // Sample path: latch the frame, replace with effect results on ack, scale and publish in APPLY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_l   <= '0;
            sample_r   <= '0;
            data_L_out <= '0;
            data_R_out <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            fx_timeout <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= frame_strobe && (state != IDLE);
            if (state == IDLE && frame_strobe) begin
                sample_l <= data_L_in;
                sample_r <= data_R_in;
            end
            if (ack_ok && state == REQ_L) begin
                sample_l <= fx_result;
            end
            if (ack_ok && state == REQ_R) begin
                sample_r <= fx_result;
            end
            if (to_hit) begin
                fx_timeout <= 1'b1;
            end
            if (state == APPLY) begin
                data_L_out <= scaled_l;
                data_R_out <= scaled_r;
                out_valid  <= 1'b1;
            end
        end
    end

    // Ramp next state: one gain step per frame, effect swapped only at silence.
    always_comb begin
        ramp_next = ramp;
        gain_next = gain;
        sel_next  = fx_sel;
        if (state == APPLY) begin
            case (ramp)
                RUN: begin
                    if (sel_pending != fx_sel) begin
                        ramp_next = DOWN;
                    end
                end
                DOWN: begin
                    gain_next = gain - GAIN_ONE;
                    if (gain == GAIN_ONE) begin
                        sel_next  = sel_pending;
                        ramp_next = UP;
                    end
                end
                UP: begin
                    gain_next = gain + GAIN_ONE;
                    if (gain == (UNITY - GAIN_ONE)) begin
                        ramp_next = RUN;
                    end
                end
                default: begin
                    ramp_next = RUN;
                end
            endcase
        end
    end

    // Ramp state, gain and active effect select registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramp   <= RUN;
            gain   <= UNITY;
            fx_sel <= '0;
        end else begin
            ramp   <= ramp_next;
            gain   <= gain_next;
            fx_sel <= sel_next;
        end
    end

    // Switch debounce: synchronise, restart the count on any change, accept after a stable run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a      <= '0;
            sync_b      <= '0;
            cand        <= '0;
            db_cnt      <= '0;
            sel_pending <= '0;
        end else begin
            sync_a <= sel_raw;
            sync_b <= sync_a;
            if (sync_b != cand) begin
                cand   <= sync_b;
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                sel_pending <= cand;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fx_scheduler.sv
// tb/tb_fx_scheduler.sv - randomized self-checking bench for fx_scheduler against a frame-level model
module tb_fx_scheduler;

    localparam int W  = 32;
    localparam int SW = 2;
    localparam int DB = 40;
    localparam int GB = 5;
    localparam int TO = 64;
    localparam int U  = 1 << GB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_strobe = 1'b0;
    logic [W-1:0]  data_L_in = '0;
    logic [W-1:0]  data_R_in = '0;
    logic [SW-1:0] sel_raw = '0;
    logic          fx_en = 1'b0;
    logic          fx_req;
    logic          fx_chan;
    logic [W-1:0]  fx_data;
    logic [SW-1:0] fx_sel;
    logic          fx_ack = 1'b0;
    logic [W-1:0]  fx_result = '0;
    logic [W-1:0]  data_L_out;
    logic [W-1:0]  data_R_out;
    logic          out_valid;
    logic          overrun;
    logic          fx_timeout;

    fx_scheduler #(
        .WIDTH(W), .SEL_W(SW), .DEBOUNCE(DB), .GAIN_BITS(GB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .frame_strobe(frame_strobe),
        .data_L_in(data_L_in), .data_R_in(data_R_in), .sel_raw(sel_raw), .fx_en(fx_en),
        .fx_req(fx_req), .fx_chan(fx_chan), .fx_data(fx_data), .fx_sel(fx_sel),
        .fx_ack(fx_ack), .fx_result(fx_result),
        .data_L_out(data_L_out), .data_R_out(data_R_out),
        .out_valid(out_valid), .overrun(overrun), .fx_timeout(fx_timeout)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Frame-level model: expected outputs per frame, ramp position, select and sticky timeout.
    typedef struct {
        logic [W-1:0]  l;
        logic [W-1:0]  r;
        logic [SW-1:0] sel;
        logic          tmo;
    } exp_t;

    exp_t          expq[$];
    exp_t          cur_e;
    bit            m_ramping = 0;
    int            m_pos = 0;
    logic [SW-1:0] m_sel = '0;
    logic [SW-1:0] m_pending = '0;
    logic          m_tmo = 1'b0;

    // Gain used by the frame at a given position of a switch: unity, down to 0, back to unity.
    function automatic int gain_at(input int pos);
        if (pos <= 1) return U;
        if (pos <= U + 1) return U + 1 - pos;
        return pos - (U + 1);
    endfunction

    function automatic logic [W-1:0] scale(input logic [W-1:0] s, input int g);
        longint p;
        p = longint'($signed(s)) * longint'(g);
        p = p >>> GB;
        return p[W-1:0];
    endfunction

    // Effect unit stand-in: acks after a per-channel delay (0 = never) with fx_data + add_val.
    int           d_l = 1;
    int           d_r = 1;
    int           ack_wait = 0;
    logic [W-1:0] add_val = '0;
    logic [W-1:0] want_l = '0;
    logic [W-1:0] want_r = '0;
    bit           late_ack = 0;
    int           ack_chan_q[$];

    initial begin
        int dd;
        forever begin
            @(posedge clk);
            #1;
            fx_ack = 1'b0;
            if (late_ack) begin
                fx_ack    = 1'b1;
                fx_result = 32'hDEAD_BEEF;
                late_ack  = 0;
            end else if (fx_req) begin
                ack_wait++;
                dd = fx_chan ? d_r : d_l;
                if (dd != 0 && ack_wait == dd) begin
                    fx_ack    = 1'b1;
                    fx_result = fx_data + add_val;
                    check("fx_data_offered", fx_data, fx_chan ? want_r : want_l);
                    ack_chan_q.push_back(int'(fx_chan));
                    ack_wait = 0;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    // Compare process: every out_valid is matched against the next modelled frame.
    bit req_seen = 0;
    int overrun_cnt = 0;

    always @(negedge clk) begin
        if (fx_req) req_seen = 1;
        if (overrun) overrun_cnt++;
        if (out_valid) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out_valid actual=1 required=0");
            end else begin
                cur_e = expq.pop_front();
                check("data_L_out", data_L_out, cur_e.l);
                check("data_R_out", data_R_out, cur_e.r);
                check("fx_sel", fx_sel, cur_e.sel);
                check("fx_timeout", fx_timeout, cur_e.tmo);
            end
        end
    end

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit en,
                              input int dl, input int dr, input int extra_at);
        exp_t e;
        int   g;
        int   lat;
        int   n;
        logic [W-1:0] wl;
        logic [W-1:0] wr;
        wl = (en && dl != 0) ? l + add_val : l;
        wr = (en && dr != 0) ? r + add_val : r;
        if (en && (dl == 0 || dr == 0)) m_tmo = 1'b1;
        if (!m_ramping && m_pending != m_sel) begin
            m_ramping = 1;
            m_pos = 0;
        end
        g = m_ramping ? gain_at(m_pos) : U;
        if (m_ramping) begin
            if (m_pos == U) m_sel = m_pending;
            if (m_pos == 2 * U) m_ramping = 0;
            else m_pos++;
        end
        e.l = scale(wl, g);
        e.r = scale(wr, g);
        e.sel = m_sel;
        e.tmo = m_tmo;
        expq.push_back(e);
        lat = en ? ((dl == 0 ? TO : dl) + (dr == 0 ? TO : dr) + 3) : 2;

        d_l = dl;
        d_r = dr;
        want_l = l;
        want_r = r;
        req_seen = 0;
        overrun_cnt = 0;
        @(posedge clk);
        #1;
        data_L_in = l;
        data_R_in = r;
        fx_en = en;
        frame_strobe = 1'b1;
        n = 0;
        while (n < 600) begin
            @(posedge clk);
            #1;
            n++;
            frame_strobe = 1'b0;
            if (out_valid) break;
            if (n == extra_at) begin
                data_L_in = $urandom;
                data_R_in = $urandom;
                frame_strobe = 1'b1;
            end
        end
        check("latency", n, lat);
        @(posedge clk);
        #1;
        check("out_valid_pulse", out_valid, 1'b0);
        check("frame_consumed", expq.size(), 0);
        if (!en) check("bypass_no_req", req_seen, 1'b0);
        if (extra_at != 0) check("overrun_pulse", overrun_cnt, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int c1;
        int dl;
        int dr;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_fx_req", fx_req, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_data_L_out", data_L_out, 32'h0);
        check("rst_data_R_out", data_R_out, 32'h0);
        check("rst_fx_sel", fx_sel, 2'd0);
        check("rst_fx_timeout", fx_timeout, 1'b0);
        check("rst_fx_data", fx_data, 32'h0);
        reset = 1'b0;

        // Bypass at unity gain.
        add_val = 32'h0;
        send_frame(32'h4000_0000, 32'hC000_0000, 0, 1, 1, 0);
        check("bypass_L", data_L_out, 32'h4000_0000);
        check("bypass_R", data_R_out, 32'hC000_0000);

        // Effect path with ack after 3 cycles.
        add_val = 32'h1;
        ack_chan_q.delete();
        send_frame(32'h1234_5678, 32'h8765_4321, 1, 3, 3, 0);
        check("effect_L", data_L_out, 32'h1234_5679);
        check("effect_R", data_R_out, 32'h8765_4322);
        c0 = ack_chan_q.size() > 0 ? ack_chan_q[0] : -1;
        c1 = ack_chan_q.size() > 1 ? ack_chan_q[1] : -1;
        check("ack_count", ack_chan_q.size(), 2);
        check("first_chan", c0, 0);
        check("second_chan", c1, 1);

        // Timeout on both channels, then a late ack in IDLE.
        send_frame(32'h0BAD_F00D, 32'hF00D_0BAD, 1, 0, 0, 0);
        check("timeout_dry_L", data_L_out, 32'h0BAD_F00D);
        check("timeout_dry_R", data_R_out, 32'hF00D_0BAD);
        check("timeout_sticky", fx_timeout, 1'b1);
        late_ack = 1;
        repeat (4) @(posedge clk);
        #1;
        check("late_ack_no_req", fx_req, 1'b0);
        check("timeout_still_set", fx_timeout, 1'b1);

        // Overrun: second strobe during REQ_L.
        add_val = $urandom;
        send_frame($urandom, $urandom, 1, 5, 5, 2);

        // Reset while a request is outstanding.
        d_l = 0;
        d_r = 0;
        @(posedge clk);
        #1;
        data_L_in = 32'h5555_AAAA;
        want_l = 32'h5555_AAAA;
        fx_en = 1'b1;
        frame_strobe = 1'b1;
        @(posedge clk);
        #1;
        frame_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("req_before_reset", fx_req, 1'b1);
        reset = 1'b1;
        #1;
        check("async_rst_fx_req", fx_req, 1'b0);
        check("async_rst_fx_data", fx_data, 32'h0);
        check("async_rst_timeout", fx_timeout, 1'b0);
        check("async_rst_data_L", data_L_out, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ramping = 0;
        m_sel = '0;
        m_pending = '0;
        m_tmo = 1'b0;
        add_val = 32'h7;
        send_frame(32'h0000_0100, 32'hFFFF_FF00, 1, 2, 4, 0);
        check("post_reset_L", data_L_out, 32'h0000_0107);

        // Bouncing select is ignored.
        for (int b = 0; b < 4; b++) begin
            sel_raw = (b % 2 == 0) ? 2'd2 : 2'd0;
            repeat (DB / 2) @(posedge clk);
        end
        repeat (DB + 10) @(posedge clk);
        send_frame(32'h4000_0000, 32'hC000_0000, 0, 1, 1, 0);
        check("bounce_no_switch", fx_sel, 2'd0);

        // Stable select: full ramp down, switch at gain 0, ramp back up.
        sel_raw = 2'd2;
        repeat (DB + 10) @(posedge clk);
        #1;
        m_pending = 2'd2;
        for (int i = 0; i <= 2 * U + 2; i++) begin
            send_frame(32'h4000_0000, 32'hC000_0000, 0, 1, 1, 0);
            if (i == 17) begin
                check("half_gain_L", data_L_out, 32'h2000_0000);
                check("half_gain_R", data_R_out, 32'hE000_0000);
            end
            if (i == U - 1) check("sel_before_zero", fx_sel, 2'd0);
            if (i == U) check("sel_at_zero", fx_sel, 2'd2);
            if (i == U + 1) check("zero_gain_L", data_L_out, 32'h0);
            if (i == 2 * U + 2) check("unity_again_L", data_L_out, 32'h4000_0000);
        end

        // Randomized frames, occasional select changes and timeouts.
        for (int k = 0; k < 50; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                sel_raw = 2'($urandom_range(0, 3));
                repeat (DB + 10) @(posedge clk);
                #1;
                m_pending = sel_raw;
            end
            add_val = $urandom;
            dl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            dr = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            send_frame($urandom, $urandom, 1'($urandom_range(0, 1)), dl, dr, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
